mdc_r2_stage: RTL and testbench
===============================

Name: mdc_r2_stage

Overview:
- Parametrised radix-2 MDC FFT stage. It replaces fixed-size per-stage blocks; one instance is used per stage with depth set by parameter.
- Each of two lanes carries frames of 2*DEPTH samples. The stage reorders them with delay lines and a commutator, pairs samples DEPTH apart, and applies a butterfly.
- The lower butterfly output is multiplied by a twiddle supplied by an external ROM.
- Adds valid gating, frame resync, rounding/saturation, optional 1/2 scaling and multiplier bypass.

Parameters:
- WIDTH, 9, signed width of each real/imag sample, in and out.
- LOG2D, 2, log2 of delay depth. DEPTH = 2^LOG2D; frame = 2*DEPTH beats per lane.
- TW_WIDTH, 9, signed twiddle width, format Q1.(TW_WIDTH-1). With TW_WIDTH=9, -1.0 = -256.
- SCALE, 0, 1 = butterfly outputs are halved with rounding.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  beat qualifier; all state advances only on beats
- in_sync  in  1  marks the first beat of a frame (sampled only with in_valid)
- mul_bypass  in  1  1 = lower output skips the twiddle multiply
- in_u_re, in_u_im  in  WIDTH each  upper lane sample
- in_l_re, in_l_im  in  WIDTH each  lower lane sample
- tw_addr  out  LOG2D  twiddle index (combinational, current beat)
- tw_re, tw_im  in  TW_WIDTH each  twiddle for tw_addr (combinational, same cycle)
- out_valid  out  1  output pair valid
- out_u_re, out_u_im  out  WIDTH each  butterfly sum
- out_l_re, out_l_im  out  WIDTH each  butterfly difference, times twiddle unless bypassed

Behaviour:
- Reset: all outputs 0, out_valid 0, beat counter cnt 0, delay lines zero, prime counter 0.
- Beat = cycle with in_valid=1. Non-beat cycles change nothing; outputs hold and out_valid drops to 0.
- Effective count e = 0 if in_sync else cnt. After a beat, cnt = e+1, wrapping mod 2*DEPTH.
- Switch s = e[LOG2D].
- Lower delay line DL: DEPTH beats on in_l.
- s=0: up_sw = in_u, lo_sw = DL_out.
- s=1: up_sw = DL_out, lo_sw = in_u.
- Upper delay line DU: DEPTH beats on up_sw. Butterfly operands: A = DU_out, B = lo_sw.
- Resulting pairing: beats n=D..2D-1 pair u[k] with u[k+D]; the following D beats pair l[k] with l[k+D].
- Butterfly, WIDTH+1 bits: sum = A+B, dif = A-B.
- SCALE=1: value = (x+1)>>>1. SCALE=0: value = x.
- Either way, the result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- tw_addr = e mod DEPTH.
- Multiply, full precision: re = dr*twr - di*twi; im = dr*twi + di*twr.
- Rounding: add 2^(TW_WIDTH-2), then >>> (TW_WIDTH-1), then saturate to WIDTH.
- mul_bypass=1: out_l = dif unchanged.
- Latency: the result for a beat is registered on that beat's clock edge, so it is visible the next cycle. Total latency is 1 cycle after the beat carrying the later operand.
- out_valid = 1 the cycle after a beat only if prime count >= DEPTH before that beat.
- Prime count increments per beat and saturates at DEPTH.
- A beat with in_sync=1 clears prime count to 0 before evaluation, so the next DEPTH beats are invalid, then output resumes.
- in_sync at e=0, i.e. already aligned, also re-primes. This is intentional: the rule is simple.
- in_sync without in_valid is ignored.
- Reset mid-frame: immediate clear. The first DEPTH beats after release produce no out_valid.
- Counter wrap from 2D-1 to 0 is seamless; the next frame's pairs follow with no gap.

Test Plan:
- LOG2D=2, SCALE=0, bypass=1, 8 contiguous beats:
  - Stimulus: u = 10,20,...,80; l = 0.
  - Beats 0-3: no out_valid.
  - Beats 4-7 outputs: out_u = 60,80,100,120; out_l = -40,-40,-40,-40 (imag 0).
- Saturation:
  - Stimulus: u[0] = u[4] = 200, SCALE=0.
  - Required: out_u_re = 255.
  - Same stimulus with SCALE=1: out_u_re = 200.
  - Stimulus: u[0] = -256, u[4] = 255, SCALE=0.
  - Required: out_l_re = -256 (saturated).
- Twiddle:
  - Stimulus: dif = (-40,0) at tw_addr=1; bench ROM returns (0,-256); bypass=0.
  - Required: out_l = (0,40).
  - Stimulus: tw = (255,0) with dif = (100,0).
  - Required: out_l = (100,0).
  - Check tw_addr sequence 0,1,2,3 across beats 4-7.
- Gapped valid:
  - Stimulus: test 1 stimulus with 1-3 idle cycles between beats.
  - Required: identical out sequence; outputs hold during gaps; out_valid pulses once per productive beat.
- Resync:
  - Stimulus: in_sync on beat 6 of a running stream.
  - Required: no out_valid for that beat and the next 3 beats; then pairs u[k], u[k+4] realigned to the sync beat; tw_addr restarts at 0.
- Reset mid-operation:
  - Stimulus: assert rst during beat 5.
  - Required: all outputs 0 and out_valid 0 at once; after release, the first 4 beats give no out_valid; beat 4 pairs with post-reset beat 0 only (no stale data).

Source files
------------

// File: rtl/mdc_r2_stage_if.sv
// Beat-level sample bus of one radix-2 MDC FFT stage, including the external twiddle ROM port.
interface mdc_r2_stage_if #(
  parameter int WIDTH    = 9,
  parameter int LOG2D    = 2,
  parameter int TW_WIDTH = 9
);
  logic                       in_valid;
  logic                       in_sync;
  logic                       mul_bypass;
  logic signed [WIDTH-1:0]    in_u_re;
  logic signed [WIDTH-1:0]    in_u_im;
  logic signed [WIDTH-1:0]    in_l_re;
  logic signed [WIDTH-1:0]    in_l_im;
  logic        [LOG2D-1:0]    tw_addr;
  logic signed [TW_WIDTH-1:0] tw_re;
  logic signed [TW_WIDTH-1:0] tw_im;
  logic                       out_valid;
  logic signed [WIDTH-1:0]    out_u_re;
  logic signed [WIDTH-1:0]    out_u_im;
  logic signed [WIDTH-1:0]    out_l_re;
  logic signed [WIDTH-1:0]    out_l_im;

  modport master (
    output in_valid, in_sync, mul_bypass, in_u_re, in_u_im, in_l_re, in_l_im, tw_re, tw_im,
    input  tw_addr, out_valid, out_u_re, out_u_im, out_l_re, out_l_im
  );

  modport slave (
    input  in_valid, in_sync, mul_bypass, in_u_re, in_u_im, in_l_re, in_l_im, tw_re, tw_im,
    output tw_addr, out_valid, out_u_re, out_u_im, out_l_re, out_l_im
  );
endinterface

// File: rtl/mdc_r2_stage.sv
// Radix-2 MDC FFT stage: delay-line/commutator reorder, butterfly with optional 1/2 scaling,
// rounded and saturated twiddle multiply on the lower output, beat-qualified with frame resync.
module mdc_r2_stage #(
  parameter int WIDTH    = 9,
  parameter int LOG2D    = 2,
  parameter int TW_WIDTH = 9,
  parameter int SCALE    = 0
) (
  input logic           clk,
  input logic           rst,
  mdc_r2_stage_if.slave bus
);
  localparam int DEPTH = 1 << LOG2D;
  // Common internal width: holds any full-precision complex product term difference exactly.
  localparam int PW = WIDTH + TW_WIDTH + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [PW-1:0] RND     = PW'(1) << (TW_WIDTH - 2);
  localparam logic [LOG2D:0]       PRIMED  = (LOG2D+1)'(DEPTH);

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  function automatic logic signed [PW-1:0] sx_d(input logic signed [WIDTH-1:0] x);
    return {{(PW-WIDTH){x[WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [PW-1:0] sx_t(input logic signed [TW_WIDTH-1:0] x);
    return {{(PW-TW_WIDTH){x[TW_WIDTH-1]}}, x};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (x < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] bfly(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] r;
    r = x + PW'(1);
    if (SCALE != 0) return sat(r >>> 1);
    return sat(x);
  endfunction

  function automatic logic signed [WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] r;
    r = x + RND;
    return sat(r >>> (TW_WIDTH - 1));
  endfunction

  cplx_t                dl [DEPTH];
  cplx_t                du [DEPTH];
  logic [LOG2D:0]       cnt, prime, e, prime_eff;
  logic                 s;
  cplx_t                in_u, up_sw, lo_sw, a, b, sum, dif, prod, low;
  cplx_t                out_u, out_l;
  logic                 out_valid;
  logic signed [PW-1:0] p_re, p_im;

  // NOTE: every target is assigned unconditionally at the top level of the block, so no latch can form.
  always_comb begin
    e         = bus.in_sync ? '0 : cnt;
    prime_eff = bus.in_sync ? '0 : prime;
    s         = e[LOG2D];
    in_u      = {bus.in_u_re, bus.in_u_im};
    up_sw     = s ? dl[DEPTH-1] : in_u;
    lo_sw     = s ? in_u : dl[DEPTH-1];
    a         = du[DEPTH-1];
    b         = lo_sw;
    sum.re    = bfly(sx_d(a.re) + sx_d(b.re));
    sum.im    = bfly(sx_d(a.im) + sx_d(b.im));
    dif.re    = bfly(sx_d(a.re) - sx_d(b.re));
    dif.im    = bfly(sx_d(a.im) - sx_d(b.im));
    p_re      = sx_d(dif.re) * sx_t(bus.tw_re) - sx_d(dif.im) * sx_t(bus.tw_im);
    p_im      = sx_d(dif.re) * sx_t(bus.tw_im) + sx_d(dif.im) * sx_t(bus.tw_re);
    prod.re   = rnd_sat(p_re);
    prod.im   = rnd_sat(p_im);
    low       = bus.mul_bypass ? dif : prod;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      prime     <= '0;
      out_valid <= 1'b0;
      out_u     <= '0;
      out_l     <= '0;
      // NOTE: the delay lines are reset too, so a restart never pairs fresh data with stale samples.
      for (int i = 0; i < DEPTH; i++) begin
        dl[i] <= '0;
        du[i] <= '0;
      end
    end else if (bus.in_valid) begin
      cnt       <= e + 1'b1;
      prime     <= (prime_eff == PRIMED) ? prime_eff : prime_eff + 1'b1;
      out_valid <= (prime_eff == PRIMED);
      out_u     <= sum;
      out_l     <= low;
      dl[0]     <= {bus.in_l_re, bus.in_l_im};
      du[0]     <= up_sw;
      for (int i = 1; i < DEPTH; i++) begin
        dl[i] <= dl[i-1];
        du[i] <= du[i-1];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign bus.tw_addr   = e[LOG2D-1:0];
  assign bus.out_valid = out_valid;
  assign bus.out_u_re  = out_u.re;
  assign bus.out_u_im  = out_u.im;
  assign bus.out_l_re  = out_l.re;
  assign bus.out_l_im  = out_l.im;
endmodule

// File: tb/tb_mdc_r2_stage.sv
// Self-checking bench: SCALE=0 and SCALE=1 stages fed identical beats, compared with a frame-level model.
module tb_mdc_r2_stage;
  localparam int W    = 9;
  localparam int L    = 2;
  localparam int TW   = 9;
  localparam int D    = 1 << L;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdc_r2_stage_if #(.WIDTH(W), .LOG2D(L), .TW_WIDTH(TW)) b0 ();
  mdc_r2_stage_if #(.WIDTH(W), .LOG2D(L), .TW_WIDTH(TW)) b1 ();

  mdc_r2_stage #(.WIDTH(W), .LOG2D(L), .TW_WIDTH(TW), .SCALE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mdc_r2_stage #(.WIDTH(W), .LOG2D(L), .TW_WIDTH(TW), .SCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  logic signed [TW-1:0] rom_re [D];
  logic signed [TW-1:0] rom_im [D];
  assign b0.tw_re = rom_re[b0.tw_addr];
  assign b0.tw_im = rom_im[b0.tw_addr];
  assign b1.tw_re = rom_re[b1.tw_addr];
  assign b1.tw_im = rom_im[b1.tw_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: per-beat history, beats since last sync/reset, last known output per stage.
  int hu_re[$], hu_im[$], hl_re[$], hl_im[$];
  int since;
  bit known;
  int kx [2][4];

  function automatic int sat(input int x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic int scl(input int x, input int sc);
    return sc != 0 ? (x + 1) >>> 1 : x;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(511, 0)) - 256;
  endfunction

  function automatic logic signed [31:0] obs(input int sc, input int k);
    case (k)
      0:       return sc == 0 ? b0.out_u_re : b1.out_u_re;
      1:       return sc == 0 ? b0.out_u_im : b1.out_u_im;
      2:       return sc == 0 ? b0.out_l_re : b1.out_l_re;
      3:       return sc == 0 ? b0.out_l_im : b1.out_l_im;
      default: return sc == 0 ? 32'(b0.out_valid) : 32'(b1.out_valid);
    endcase
  endfunction

  task automatic drive(input bit v, input bit sy, input bit byp, input int ur, input int ui, input int lr, input int li);
    b0.in_valid = v;     b1.in_valid = v;
    b0.in_sync = sy;     b1.in_sync = sy;
    b0.mul_bypass = byp; b1.mul_bypass = byp;
    b0.in_u_re = W'(ur); b1.in_u_re = W'(ur);
    b0.in_u_im = W'(ui); b1.in_u_im = W'(ui);
    b0.in_l_re = W'(lr); b1.in_l_re = W'(lr);
    b0.in_l_im = W'(li); b1.in_l_im = W'(li);
  endtask

  // One clock cycle: a beat when v=1, otherwise an idle cycle whose outputs must hold.
  task automatic step(input bit v, input bit sy, input bit byp, input int ur, input int ui, input int lr, input int li);
    int e, b, ar, ai, br, bi, sr, si, dr, di, twr, twi, pr, pi;
    bit vld;
    int ex [2][4];
    string nm [4];
    nm = '{"u_re", "u_im", "l_re", "l_im"};
    vld = 1'b0;
    drive(v, sy, byp, ur, ui, lr, li);
    #1;
    if (v) begin
      if (sy) since = 0;
      e = since % (2 * D);
      check("tw_addr0", 32'(b0.tw_addr), e % D);
      check("tw_addr1", 32'(b1.tw_addr), e % D);
      hu_re.push_back(ur); hu_im.push_back(ui);
      hl_re.push_back(lr); hl_im.push_back(li);
      b   = hu_re.size() - 1;
      vld = since >= D;
      if (vld) begin
        if (e >= D) begin
          ar = hu_re[b-D]; ai = hu_im[b-D]; br = ur; bi = ui;
        end else begin
          ar = hl_re[b-2*D]; ai = hl_im[b-2*D]; br = hl_re[b-D]; bi = hl_im[b-D];
        end
        twr = int'(rom_re[e % D]);
        twi = int'(rom_im[e % D]);
        for (int sc = 0; sc < 2; sc++) begin
          sr = sat(scl(ar + br, sc)); si = sat(scl(ai + bi, sc));
          dr = sat(scl(ar - br, sc)); di = sat(scl(ai - bi, sc));
          ex[sc][0] = sr;
          ex[sc][1] = si;
          if (byp) begin
            ex[sc][2] = dr;
            ex[sc][3] = di;
          end else begin
            pr = dr * twr - di * twi;
            pi = dr * twi + di * twr;
            ex[sc][2] = sat((pr + (1 << (TW - 2))) >>> (TW - 1));
            ex[sc][3] = sat((pi + (1 << (TW - 2))) >>> (TW - 1));
          end
        end
      end
      since++;
    end
    @(posedge clk);
    #1;
    for (int sc = 0; sc < 2; sc++) begin
      check($sformatf("valid%0d", sc), obs(sc, 4), (v && vld) ? 1 : 0);
      if (v && vld) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("%s%0d", nm[k], sc), obs(sc, k), ex[sc][k]);
          kx[sc][k] = ex[sc][k];
        end
      end else if (!v && known) begin
        for (int k = 0; k < 4; k++) check($sformatf("hold_%s%0d", nm[k], sc), obs(sc, k), kx[sc][k]);
      end
    end
    if (v) known = vld;
  endtask

  task automatic model_reset();
    since = 0;
    known = 1'b1;
    for (int sc = 0; sc < 2; sc++) for (int k = 0; k < 4; k++) kx[sc][k] = 0;
  endtask

  task automatic check_cleared(input string tag);
    for (int sc = 0; sc < 2; sc++)
      for (int k = 0; k < 5; k++) check($sformatf("%s_%0d_%0d", tag, sc, k), obs(sc, k), 0);
  endtask

  initial begin
    int u [8];
    for (int i = 0; i < D; i++) begin rom_re[i] = TW'(255); rom_im[i] = '0; end
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0);
    model_reset();
    #12;
    check_cleared("reset");
    check("reset_tw_addr", 32'(b0.tw_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Contiguous frame, bypassed multiplier.
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 1, 10 * (i + 1), 0, 0, 0);
      if (i >= 4) begin
        check("t1_u_re", b0.out_u_re, 60 + 20 * (i - 4));
        check("t1_l_re", b0.out_l_re, -40);
        check("t1_l_im", b0.out_l_im, 0);
      end
    end

    // Saturation of the sum, and halving on the scaled stage.
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 1, (i % 4 == 0) ? 200 : 0, 0, 0, 0);
      if (i == 4) begin
        check("sat_u_s0", b0.out_u_re, 255);
        check("sat_u_s1", b1.out_u_re, 200);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 1, (i == 0) ? -256 : (i == 4) ? 255 : 0, 0, 0, 0);
      if (i == 4) check("sat_l_s0", b0.out_l_re, -256);
    end

    // Twiddle multiply: -j on index 1, ~1.0 on index 3.
    rom_re[1] = '0;       rom_im[1] = TW'(-256);
    rom_re[3] = TW'(255); rom_im[3] = '0;
    u = '{10, 20, 30, 140, 50, 60, 70, 40};
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 0, u[i], 0, 0, 0);
      if (i == 5) begin
        check("tw_j_re", b0.out_l_re, 0);
        check("tw_j_im", b0.out_l_im, 40);
      end
      if (i == 7) begin
        check("tw_one_re", b0.out_l_re, 100);
        check("tw_one_im", b0.out_l_im, 0);
      end
    end

    // Gapped beats: same results, outputs hold across idle cycles.
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, 1, 10 * (i + 1), 0, 0, 0);
      if (i >= 4) check("gap_u_re", b0.out_u_re, 60 + 20 * (i - 4));
      repeat ($urandom_range(3, 1)) step(0, $urandom_range(1, 0), 1, rnd(), rnd(), rnd(), rnd());
    end

    // Resync in a running stream on beat 6.
    for (int i = 0; i < 20; i++) step(1, i == 0 || i == 6, $urandom_range(1, 0), rnd(), rnd(), rnd(), rnd());

    // Long randomized stream: gaps, occasional syncs (with and without valid), random twiddles.
    for (int i = 0; i < D; i++) begin rom_re[i] = TW'(rnd()); rom_im[i] = TW'(rnd()); end
    for (int i = 0; i < 300; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0, $urandom_range(1, 0),
           rnd(), rnd(), rnd(), rnd());

    // Reset during beat 5 of a frame.
    for (int i = 0; i < 5; i++) step(1, i == 0, 0, rnd(), rnd(), rnd(), rnd());
    drive(1, 0, 0, rnd(), rnd(), rnd(), rnd());
    #2 rst = 1'b1;
    #1;
    check_cleared("midrst");
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1, 0, $urandom_range(1, 0), rnd(), rnd(), rnd(), rnd());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
